// File: rtl/boot_copy_ctrl.sv
// Boot copy controller: holds the CPU in reset while streaming NUM_WORDS words
// from the boot ROM into program RAM at DST_BASE, then releases the CPU.
// Optional read-back check of the copied image is enabled with the
// BOOT_COPY_VERIFY_EN macro; without it VERIFY/ERROR are never entered.
module boot_copy_ctrl #(
  parameter int unsigned NUM_WORDS      = 256,
  parameter int unsigned RAM_ADDR_WIDTH = 8,
  parameter int unsigned DST_BASE       = 0,
  parameter int unsigned IDX_WIDTH      = 9
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      reboot,
  output logic [31:0]               rom_raddr,
  input  logic [31:0]               rom_rdata,
  output logic                      ram_wen,
  output logic [RAM_ADDR_WIDTH-1:0] ram_waddr,
  output logic [31:0]               ram_wdata,
  output logic                      ram_ren,
  output logic [RAM_ADDR_WIDTH-1:0] ram_raddr,
  input  logic [31:0]               ram_rdata,
  output logic                      cpu_resetn,
  output logic                      busy,
  output logic                      done,
  output logic                      verify_err,
  output logic [RAM_ADDR_WIDTH-1:0] err_addr
);

  typedef enum logic [2:0] {StIdle, StCopy, StVerify, StDone, StError} state_e;

  localparam logic [IDX_WIDTH-1:0]      NumIdx  = IDX_WIDTH'(NUM_WORDS);
  localparam logic [IDX_WIDTH-1:0]      LastIdx = IDX_WIDTH'(NUM_WORDS - 1);
  localparam logic [RAM_ADDR_WIDTH-1:0] Base    = RAM_ADDR_WIDTH'(DST_BASE);

  state_e                    state_q, state_d;
  logic [IDX_WIDTH-1:0]      rd_idx_q, rd_idx_d;
  logic [IDX_WIDTH-1:0]      wr_idx_q, wr_idx_d;
  logic                      wr_vld_q, wr_vld_d;
  logic                      cpu_resetn_q, cpu_resetn_d;
  logic                      done_q, done_d;
  logic                      verify_err_q, verify_err_d;
  logic [RAM_ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic                      more;

  // Issue side still has ROM indices left to present.
  assign more = (rd_idx_q < NumIdx);

  // State register and pipeline registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      rd_idx_q     <= '0;
      wr_idx_q     <= '0;
      wr_vld_q     <= 1'b0;
      cpu_resetn_q <= 1'b0;
      done_q       <= 1'b0;
      verify_err_q <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      rd_idx_q     <= rd_idx_d;
      wr_idx_q     <= wr_idx_d;
      wr_vld_q     <= wr_vld_d;
      cpu_resetn_q <= cpu_resetn_d;
      done_q       <= done_d;
      verify_err_q <= verify_err_d;
      err_addr_q   <= err_addr_d;
    end
  end

  // Next-state logic: issue/write pipeline shared by COPY and VERIFY.
  always_comb begin
    state_d      = state_q;
    rd_idx_d     = rd_idx_q;
    wr_idx_d     = wr_idx_q;
    wr_vld_d     = 1'b0;
    cpu_resetn_d = cpu_resetn_q;
    done_d       = done_q;
    verify_err_d = verify_err_q;
    err_addr_d   = err_addr_q;

    unique case (state_q)
      StIdle: begin
        state_d      = StCopy;
        rd_idx_d     = '0;
        cpu_resetn_d = 1'b0;
        done_d       = 1'b0;
      end

      StCopy: begin
        if (more) begin
          rd_idx_d = rd_idx_q + 1'b1;
          wr_vld_d = 1'b1;
          wr_idx_d = rd_idx_q;
        end
        // Last write lands on this edge; leave COPY at the same time.
        if (wr_vld_q && (wr_idx_q == LastIdx)) begin
          wr_vld_d = 1'b0;
          rd_idx_d = '0;
`ifdef BOOT_COPY_VERIFY_EN
          state_d  = StVerify;
`else
          state_d      = StDone;
          done_d       = 1'b1;
          cpu_resetn_d = 1'b1;
`endif
        end
      end

`ifdef BOOT_COPY_VERIFY_EN
      StVerify: begin
        if (more) begin
          rd_idx_d = rd_idx_q + 1'b1;
          wr_vld_d = 1'b1;
          wr_idx_d = rd_idx_q;
        end
        if (wr_vld_q) begin
          if (rom_rdata != ram_rdata) begin
            // First mismatch ends the pass.
            state_d      = StError;
            verify_err_d = 1'b1;
            err_addr_d   = Base + RAM_ADDR_WIDTH'(wr_idx_q);
            wr_vld_d     = 1'b0;
            rd_idx_d     = '0;
          end else if (wr_idx_q == LastIdx) begin
            state_d      = StDone;
            done_d       = 1'b1;
            cpu_resetn_d = 1'b1;
            wr_vld_d     = 1'b0;
            rd_idx_d     = '0;
          end
        end
      end
`endif

      StDone, StError: begin
        if (reboot) begin
          state_d      = StCopy;
          rd_idx_d     = '0;
          cpu_resetn_d = 1'b0;
          done_d       = 1'b0;
          verify_err_d = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign rom_raddr  = 32'({rd_idx_q, 2'b00});
  assign ram_wen    = (state_q == StCopy) && wr_vld_q;
  assign ram_waddr  = Base + RAM_ADDR_WIDTH'(wr_idx_q);
  assign ram_wdata  = rom_rdata;
  assign cpu_resetn = cpu_resetn_q;
  assign busy       = (state_q == StCopy) || (state_q == StVerify);
  assign done       = done_q;
  assign verify_err = verify_err_q;
  assign err_addr   = err_addr_q;

`ifdef BOOT_COPY_VERIFY_EN
  assign ram_ren   = (state_q == StVerify) && more;
  assign ram_raddr = (state_q == StVerify) ? (Base + RAM_ADDR_WIDTH'(rd_idx_q)) : '0;
`else
  logic unused_rdata;
  assign unused_rdata = ^ram_rdata;
  assign ram_ren      = 1'b0;
  assign ram_raddr    = '0;
`endif

endmodule

// File: tb/tb_boot_copy_ctrl.sv
// Scoreboard bench for boot_copy_ctrl: two instances (DST_BASE 0 and 254),
// behavioural ROM/RAM models, expected writes queued at stimulus time.
module tb_boot_copy_ctrl;

`ifdef BOOT_COPY_VERIFY_EN
  localparam int DoneEdges = 11;  // 1 (IDLE) + 5 (COPY) + 5 (VERIFY)
`else
  localparam int DoneEdges = 6;   // 1 (IDLE) + 5 (COPY)
`endif

  logic        clk = 1'b0;
  logic        resetn, resetn_w, reboot, corrupt_req;

  logic [31:0] rom_raddr, rom_rdata, ram_wdata, ram_rdata;
  logic [7:0]  ram_waddr, ram_raddr, err_addr;
  logic        ram_wen, ram_ren, cpu_resetn, busy, done, verify_err;

  logic [31:0] rom_raddr_w, rom_rdata_w, ram_wdata_w, ram_rdata_w;
  logic [7:0]  ram_waddr_w, ram_raddr_w, err_addr_w;
  logic        ram_wen_w, ram_ren_w, cpu_resetn_w, busy_w, done_w, verify_err_w;

  logic [31:0] rom   [256];
  logic [31:0] mem   [256];
  logic [31:0] mem_w [256];

  logic [39:0] exp_q   [$];
  logic [39:0] exp_w_q [$];
  logic [39:0] exp_e;
  int tests = 0;
  int fails = 0;
  int wr_seen = 0;

  always #5 clk = ~clk;

  boot_copy_ctrl #(
    .NUM_WORDS(4), .RAM_ADDR_WIDTH(8), .DST_BASE(0), .IDX_WIDTH(9)
  ) dut (
    .clk(clk), .resetn(resetn), .reboot(reboot),
    .rom_raddr(rom_raddr), .rom_rdata(rom_rdata),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .cpu_resetn(cpu_resetn), .busy(busy), .done(done),
    .verify_err(verify_err), .err_addr(err_addr)
  );

  boot_copy_ctrl #(
    .NUM_WORDS(4), .RAM_ADDR_WIDTH(8), .DST_BASE(254), .IDX_WIDTH(9)
  ) dut_w (
    .clk(clk), .resetn(resetn_w), .reboot(1'b0),
    .rom_raddr(rom_raddr_w), .rom_rdata(rom_rdata_w),
    .ram_wen(ram_wen_w), .ram_waddr(ram_waddr_w), .ram_wdata(ram_wdata_w),
    .ram_ren(ram_ren_w), .ram_raddr(ram_raddr_w), .ram_rdata(ram_rdata_w),
    .cpu_resetn(cpu_resetn_w), .busy(busy_w), .done(done_w),
    .verify_err(verify_err_w), .err_addr(err_addr_w)
  );

  // ROM and RAM models, all with one-cycle read latency.
  always @(posedge clk) begin
    rom_rdata   <= rom[rom_raddr[9:2]];
    rom_rdata_w <= rom[rom_raddr_w[9:2]];
    if (ram_wen)     mem[ram_waddr]     <= ram_wdata;
    if (corrupt_req) mem[2]             <= 32'hDEAD;
    if (ram_ren)     ram_rdata          <= mem[ram_raddr];
    if (ram_wen_w)   mem_w[ram_waddr_w] <= ram_wdata_w;
    if (ram_ren_w)   ram_rdata_w        <= mem_w[ram_raddr_w];
  end

  // Monitor: every RAM write must match the head of its expected queue.
  always @(negedge clk) begin
    if (ram_wen) begin
      tests++;
      wr_seen++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_write: unexpected write addr %0d data %0h", ram_waddr, ram_wdata);
      end else begin
        exp_e = exp_q.pop_front();
        if ({ram_waddr, ram_wdata} !== exp_e) begin
          fails++;
          $display("FAIL sb_write: got addr %0d data %0h, expected addr %0d data %0h",
                   ram_waddr, ram_wdata, exp_e[39:32], exp_e[31:0]);
        end
      end
    end
    if (ram_wen_w) begin
      tests++;
      if (exp_w_q.size() == 0) begin
        fails++;
        $display("FAIL sb_wrap: unexpected write addr %0d data %0h", ram_waddr_w, ram_wdata_w);
      end else begin
        exp_e = exp_w_q.pop_front();
        if ({ram_waddr_w, ram_wdata_w} !== exp_e) begin
          fails++;
          $display("FAIL sb_wrap: got addr %0d data %0h, expected addr %0d data %0h",
                   ram_waddr_w, ram_wdata_w, exp_e[39:32], exp_e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected write stream for one full copy (hand-computed addresses/data).
  task automatic push_main();
    exp_q.push_back({8'd0, 32'h11});
    exp_q.push_back({8'd1, 32'h22});
    exp_q.push_back({8'd2, 32'h33});
    exp_q.push_back({8'd3, 32'h44});
  endtask

  task automatic push_wrap();
    exp_w_q.push_back({8'd254, 32'h11});
    exp_w_q.push_back({8'd255, 32'h22});
    exp_w_q.push_back({8'd0,   32'h33});
    exp_w_q.push_back({8'd1,   32'h44});
  endtask

  // Count edges until done rises; optionally pulse reboot before edge pulse_at.
  task automatic wait_done(input int exp_edges, input int pulse_at, input string name);
    int n;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == pulse_at) reboot = 1'b1;
      @(posedge clk);
      #1;
      reboot = 1'b0;
      if (done) begin
        n = i;
        break;
      end
    end
    check(name, n, exp_edges);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_base;
    for (int i = 0; i < 256; i++) rom[i] = 32'h1000 + i;
    rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;
    resetn = 1'b0; resetn_w = 1'b0; reboot = 1'b0; corrupt_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    check("rst_cpu_resetn", cpu_resetn, 0);
    check("rst_busy",       busy,       0);
    check("rst_done",       done,       0);
    check("rst_verify_err", verify_err, 0);
    check("rst_err_addr",   err_addr,   0);
    check("rst_ram_wen",    ram_wen,    0);
    check("rst_ram_ren",    ram_ren,    0);
    check("rst_rom_raddr",  rom_raddr,  0);

    // Test 1 and 2: plain copy, and wrapping copy on the second instance
    push_main();
    push_wrap();
    resetn = 1'b1;
    resetn_w = 1'b1;
    wait_done(DoneEdges, 0, "t1_done_edges");
    check("t1_cpu_resetn", cpu_resetn, 1);
    check("t1_busy",       busy,       0);
    check("t1_ram_wen",    ram_wen,    0);
    check("t1_verify_err", verify_err, 0);
    check("t1_queue_empty", exp_q.size(), 0);
    check("t1_ram_word0",  mem[0], 32'h11);
    check("t1_ram_word3",  mem[3], 32'h44);
    check("t2_done",       done_w, 1);
    check("t2_queue_empty", exp_w_q.size(), 0);
    check("t2_ram_word254", mem_w[254], 32'h11);
    check("t2_ram_word1",   mem_w[1],   32'h44);

    // Test 4: reboot from DONE, then a reboot pulse during COPY is ignored
    push_main();
    reboot = 1'b1;
    @(posedge clk);
    #1;
    reboot = 1'b0;
    check("t4_done_cleared", done,       0);
    check("t4_cpu_held",     cpu_resetn, 0);
    check("t4_busy",         busy,       1);
    wait_done(DoneEdges - 1, 0, "t4_done_edges");
    check("t4_queue_empty", exp_q.size(), 0);
    push_main();
    reboot = 1'b1;
    @(posedge clk);
    #1;
    reboot = 1'b0;
    wait_done(DoneEdges - 1, 3, "t4_mid_reboot_edges");
    check("t4_mid_queue_empty", exp_q.size(), 0);

    // Test 3: reset asserted after two writes, then a clean restart
    resetn = 1'b0;
    @(posedge clk);
    #1;
    push_main();
    resetn = 1'b1;
    wr_base = wr_seen;
    repeat (4) @(posedge clk);  // E0..E3: writes of index 0 and 1 completed
    #1;
    resetn = 1'b0;
    #1;
    check("t3_cpu_resetn",  cpu_resetn, 0);
    check("t3_ram_wen",     ram_wen,    0);
    check("t3_busy",        busy,       0);
    check("t3_rom_raddr",   rom_raddr,  0);
    check("t3_writes_seen", wr_seen - wr_base, 2);
    exp_q.delete();  // indices 2 and 3 are never written
    @(posedge clk);
    #1;
    push_main();
    resetn = 1'b1;
    wait_done(DoneEdges, 0, "t3_restart_edges");
    check("t3_queue_empty", exp_q.size(), 0);

`ifdef BOOT_COPY_VERIFY_EN
    // Test 5: corrupt RAM word 2 after copy, before it is read back
    begin
      int n;
      n = 0;
      push_main();
      reboot = 1'b1;
      @(posedge clk);
      #1;
      reboot = 1'b0;
      for (int i = 1; i <= 40; i++) begin
        @(posedge clk);
        #1;
        corrupt_req = (i == 5);
        if (verify_err) begin
          n = i;
          break;
        end
      end
      corrupt_req = 1'b0;
      check("t5_err_edges",   n,          9);
      check("t5_verify_err",  verify_err, 1);
      check("t5_err_addr",    err_addr,   2);
      check("t5_cpu_held",    cpu_resetn, 0);
      check("t5_done",        done,       0);
      check("t5_busy",        busy,       0);
    end

    // Reboot from ERROR with a clean image: verify passes
    push_main();
    reboot = 1'b1;
    @(posedge clk);
    #1;
    reboot = 1'b0;
    check("t6_err_cleared", verify_err, 0);
    wait_done(DoneEdges - 1, 0, "t6_done_edges");
    check("t6_cpu_resetn", cpu_resetn, 1);
    check("t6_queue_empty", exp_q.size(), 0);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("end_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/boot_copy_ctrl.md
Name: boot_copy_ctrl

Overview:
- Boot sequencer between the bootloader ROM and main program RAM.
- After reset it holds the CPU in reset and streams NUM_WORDS words from the ROM into RAM at DST_BASE, one word per cycle, pipelined around the ROM's 1-cycle synchronous read.
- When the copy completes it releases the CPU. A software or debug reboot pulse re-runs the sequence.

Parameters:
- NUM_WORDS, 256: words to copy, 1..2^RAM_ADDR_WIDTH.
- RAM_ADDR_WIDTH, 8: target RAM word-address width.
- DST_BASE, 0: first target word address. Addresses wrap modulo 2^RAM_ADDR_WIDTH.
- IDX_WIDTH, 9: counter width. Must satisfy 2^IDX_WIDTH > NUM_WORDS.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- reboot  in  1  one-cycle pulse that restarts the copy; honoured only in DONE or ERROR.
- rom_raddr  out  32  ROM byte address, equal to {idx, 2'b00}. The ROM uses bits [31:2].
- rom_rdata  in  32  ROM data, valid one cycle after the address is sampled.
- ram_wen  out  1  target RAM write enable.
- ram_waddr  out  RAM_ADDR_WIDTH  target RAM word address.
- ram_wdata  out  32  write data, wired directly from rom_rdata.
- ram_ren  out  1  target RAM read enable (verify only).
- ram_raddr  out  RAM_ADDR_WIDTH  target RAM read address (verify only).
- ram_rdata  in  32  target RAM read data, 1-cycle latency.
- cpu_resetn  out  1  CPU reset, active-low, registered.
- busy  out  1  high in COPY or VERIFY.
- done  out  1  high in DONE.
- verify_err  out  1  high in ERROR.
- err_addr  out  RAM_ADDR_WIDTH  target address of the first mismatch.

Behaviour:
- States: IDLE, COPY, VERIFY, DONE, ERROR. The reset state is IDLE.
- Reset values: cpu_resetn=0, busy=0, done=0, verify_err=0, err_addr=0, ram_wen=0, ram_ren=0, rom_raddr=0, all internal counters 0.
- Reset is honoured mid-copy: on assertion everything returns to IDLE, cpu_resetn drops immediately, and a partially written RAM is left as is.
- IDLE:
  - The first edge after resetn deasserts moves to COPY with rd_idx=0.
  - cpu_resetn is held 0.
- COPY, issue side:
  - rom_raddr = rd_idx<<2 while rd_idx < NUM_WORDS.
  - At each edge where an address is issued, rd_idx increments and a write slot is queued: wr_vld<=1, wr_idx<=rd_idx.
- COPY, write side:
  - ram_wen=wr_vld.
  - ram_waddr = (DST_BASE + wr_idx) truncated to RAM_ADDR_WIDTH.
  - ram_wdata = rom_rdata.
- COPY timing:
  - Entry edge is E0. ROM samples index k at edge E(k+1); RAM writes index k at edge E(k+2).
  - Exactly NUM_WORDS writes occur, with no gaps and no duplicates.
  - The last write happens at edge E(NUM_WORDS+1). At that same edge the state advances to VERIFY (macro defined) or DONE, and wr_vld clears.
- DONE:
  - done=1 and cpu_resetn=1, both registered in the same edge that enters DONE.
  - ram_wen=0; RAM ports idle.
- reboot:
  - In DONE or ERROR: next edge goes to COPY, rd_idx=0, cpu_resetn=0, done=0, verify_err=0.
  - In IDLE, COPY or VERIFY: ignored, no effect.
- NUM_WORDS=1: a single write at E2, then DONE/VERIFY.
- Wrap example: DST_BASE + k ≥ 2^RAM_ADDR_WIDTH wraps to low addresses.

Optional Feature:
- Macro: BOOT_COPY_VERIFY_EN.
- Defined, VERIFY pass:
  - Reissues ROM index k and RAM address DST_BASE+k together, one per cycle, with ram_ren=1.
  - Compares rom_rdata with ram_rdata one cycle later, pipelined like COPY.
  - On the first mismatch: capture err_addr, enter ERROR (verify_err=1, cpu_resetn stays 0, busy=0), and abandon the rest of the pass.
  - All NUM_WORDS match: enter DONE NUM_WORDS+1 cycles after VERIFY entry.
- Not defined:
  - VERIFY and ERROR are unreachable; COPY goes directly to DONE.
  - ram_ren=0, ram_raddr=0, verify_err=0, err_addr=0 constantly.
  - ram_rdata is unused.

Test Plan:
1. NUM_WORDS=4, DST_BASE=0, ROM = 11,22,33,44, deassert resetn → ram_wen high for 4 consecutive cycles, addresses 0,1,2,3, data 11,22,33,44; done=1 and cpu_resetn=1 exactly 6 edges after the resetn release edge (macro off).
2. NUM_WORDS=4, DST_BASE=254, RAM_ADDR_WIDTH=8 → writes land at 254,255,0,1.
3. Assert resetn low after 2 of 4 writes → cpu_resetn=0 and ram_wen=0 immediately; after release the copy restarts from ROM address 0.
4. After DONE, pulse reboot for one cycle → done=0, cpu_resetn=0, 4 writes repeat; a reboot pulse during COPY leaves the write sequence unchanged.
5. Macro on, bench corrupts RAM word 2 (writes 0xDEAD) before its VERIFY read → verify_err=1, err_addr=2, cpu_resetn stays 0, done=0.
6. Macro on, no corruption → VERIFY passes, done=1, total from COPY entry to DONE = (N+1)+(N+1) cycles.
